// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared widths and the packed E-stage control bundle layout for the RV32I pipeline.
// The bundle field offsets are fixed; downstream code indexes the bundle with them.
package riscv_pipe_pkg;

   localparam int RESULTSRC_W = 2;
   localparam int BRANCH_W    = 2;
   localparam int ALUCTRL_W   = 3;
   localparam int FUNCT3_W    = 3;

   // Bit offsets within the control bundle, LSB first. Do not reorder.
   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMWRITE  = 1;
   localparam int CTRL_JUMP      = 2;
   localparam int CTRL_ALUSRC    = 3;
   localparam int CTRL_SELADDER  = 4;
   localparam int CTRL_RESULTSRC = 5;
   localparam int CTRL_BRANCH    = CTRL_RESULTSRC + RESULTSRC_W;
   localparam int CTRL_ALUCTRL   = CTRL_BRANCH + BRANCH_W;
   localparam int CTRL_FUNCT3    = CTRL_ALUCTRL + ALUCTRL_W;
   localparam int CTRL_W         = CTRL_FUNCT3 + FUNCT3_W;

   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   // Strip the fields that change architectural state (register write, store, jump, branch).
   function automatic logic [CTRL_W-1:0] ctrl_kill_effects(input logic [CTRL_W-1:0] c);
      logic [CTRL_W-1:0] r;
      r = c;
      r[CTRL_REGWRITE]             = 1'b0;
      r[CTRL_MEMWRITE]             = 1'b0;
      r[CTRL_JUMP]                 = 1'b0;
      r[CTRL_BRANCH +: BRANCH_W]   = '0;
      return r;
   endfunction

endpackage

// File: rtl/id_ex_pipe_reg_en_clr.sv
// Generic synchronous register: rst and clr both zero it (clr beats en), en loads d.
module pipe_reg_en_clr
   import riscv_pipe_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush (bubble) and stall (hold), plus a per-stage valid bit.
// Define ID_EX_BUBBLE_CNT_EN to count loaded bubbles on BubbleCntE; otherwise it reads 0.
module id_ex_pipe_reg
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   StallE,
   input  logic                   FlushE,
   input  logic                   ValidD,
   input  logic                   RegWriteD,
   input  logic                   MemWriteD,
   input  logic                   JumpD,
   input  logic                   ALUSrcD,
   input  logic                   sel_adderD,
   input  logic [RESULTSRC_W-1:0] ResultSrcD,
   input  logic [BRANCH_W-1:0]    BranchD,
   input  logic [ALUCTRL_W-1:0]   ALUControlD,
   input  logic [FUNCT3_W-1:0]    funct3D,
   input  logic [XLEN-1:0]        RD1D,
   input  logic [XLEN-1:0]        RD2D,
   input  logic [XLEN-1:0]        PCD,
   input  logic [XLEN-1:0]        PCPlus4D,
   input  logic [XLEN-1:0]        ImmExtD,
   input  logic [REG_AW-1:0]      Rs1D,
   input  logic [REG_AW-1:0]      Rs2D,
   input  logic [REG_AW-1:0]      RdD,
   output logic                   RegWriteE,
   output logic                   MemWriteE,
   output logic                   JumpE,
   output logic                   ALUSrcE,
   output logic                   sel_adderE,
   output logic [RESULTSRC_W-1:0] ResultSrcE,
   output logic [BRANCH_W-1:0]    BranchE,
   output logic [ALUCTRL_W-1:0]   ALUControlE,
   output logic [FUNCT3_W-1:0]    funct3E,
   output logic [XLEN-1:0]        RD1E,
   output logic [XLEN-1:0]        RD2E,
   output logic [XLEN-1:0]        PCE,
   output logic [XLEN-1:0]        PCPlus4E,
   output logic [XLEN-1:0]        ImmExtE,
   output logic [REG_AW-1:0]      Rs1E,
   output logic [REG_AW-1:0]      Rs2E,
   output logic [REG_AW-1:0]      RdE,
   output logic                   ValidE,
   output logic [31:0]            BubbleCntE
);

   localparam int DATA_W = 5 * XLEN + 3 * REG_AW;

   logic [CTRL_W-1:0] ctrl_d, ctrl_ld, ctrl_q;
   logic [DATA_W-1:0] data_d, data_q;

   always_comb begin
      ctrl_d                                 = CTRL_NOP;
      ctrl_d[CTRL_REGWRITE]                  = RegWriteD;
      ctrl_d[CTRL_MEMWRITE]                  = MemWriteD;
      ctrl_d[CTRL_JUMP]                      = JumpD;
      ctrl_d[CTRL_ALUSRC]                    = ALUSrcD;
      ctrl_d[CTRL_SELADDER]                  = sel_adderD;
      ctrl_d[CTRL_RESULTSRC +: RESULTSRC_W]  = ResultSrcD;
      ctrl_d[CTRL_BRANCH +: BRANCH_W]        = BranchD;
      ctrl_d[CTRL_ALUCTRL +: ALUCTRL_W]      = ALUControlD;
      ctrl_d[CTRL_FUNCT3 +: FUNCT3_W]        = funct3D;
   end

   // An invalid D-stage slot may carry stale controls; never let it commit anything.
   assign ctrl_ld = ValidD ? ctrl_d : ctrl_kill_effects(ctrl_d);
   assign data_d  = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};

   pipe_reg_en_clr #(.WIDTH(CTRL_W)) u_ctrl (
      .clk (clk),
      .rst (rst),
      .clr (FlushE),
      .en  (~StallE),
      .d   (ctrl_ld),
      .q   (ctrl_q)
   );

   pipe_reg_en_clr #(.WIDTH(DATA_W)) u_data (
      .clk (clk),
      .rst (rst),
      .clr (FlushE),
      .en  (~StallE),
      .d   (data_d),
      .q   (data_q)
   );

   assign RegWriteE   = ctrl_q[CTRL_REGWRITE];
   assign MemWriteE   = ctrl_q[CTRL_MEMWRITE];
   assign JumpE       = ctrl_q[CTRL_JUMP];
   assign ALUSrcE     = ctrl_q[CTRL_ALUSRC];
   assign sel_adderE  = ctrl_q[CTRL_SELADDER];
   assign ResultSrcE  = ctrl_q[CTRL_RESULTSRC +: RESULTSRC_W];
   assign BranchE     = ctrl_q[CTRL_BRANCH +: BRANCH_W];
   assign ALUControlE = ctrl_q[CTRL_ALUCTRL +: ALUCTRL_W];
   assign funct3E     = ctrl_q[CTRL_FUNCT3 +: FUNCT3_W];

   assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE} = data_q;

   always_ff @(posedge clk) begin
      if (rst || FlushE) begin
         ValidE <= 1'b0;
      end else if (!StallE) begin
         ValidE <= ValidD;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q;
   logic        bubble_ld;

   assign bubble_ld = FlushE || (!StallE && !ValidD);

   // Saturating: a stuck-high flush must not wrap the count back to a small value.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
      end else if (bubble_ld && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign BubbleCntE = bubble_cnt_q;
`else
   assign BubbleCntE = 32'd0;
`endif

endmodule
